// File: rtl/matrix_frame_sequencer_if.sv
// Handshake and frame-buffer bus between the frame sequencer, the frame buffer
// and output_module.
interface matrix_frame_sequencer_if #(
  parameter int CHANNEL_NUMBER = 3,
  parameter int SPI_SIZE       = 8,
  parameter int ADDR_WIDTH     = 9
);
  logic                               enable;
  logic [1:0]                         mode;
  logic [SPI_SIZE-1:0]                fill_word;
  logic                               rd_en;
  logic [ADDR_WIDTH-1:0]              rd_addr;
  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] rd_data;
  logic [CHANNEL_NUMBER*SPI_SIZE-1:0] data_out;
  logic                               new_image;
  logic                               next_data;
  logic                               new_column;
  logic                               tx_finish;
  logic                               busy;
  logic                               frame_done;
  logic [15:0]                        frame_count;
  logic                               ack_error;

  modport master (
    input  enable, mode, fill_word, rd_data, tx_finish,
    output rd_en, rd_addr, data_out, new_image, next_data, new_column,
           busy, frame_done, frame_count, ack_error
  );

  modport slave (
    output enable, mode, fill_word, rd_data, tx_finish,
    input  rd_en, rd_addr, data_out, new_image, next_data, new_column,
           busy, frame_done, frame_count, ack_error
  );
endinterface

// File: rtl/matrix_frame_sequencer.sv
// Streams one LED-matrix frame per channel into output_module, sourcing words
// from the frame buffer or a built-in test pattern.
module matrix_frame_sequencer #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int BYTES_PER_MATRIX = 384,
  parameter int BYTES_PER_COLUMN = 24,
  parameter int ACK_TIMEOUT      = 1023,
  parameter int ADDR_WIDTH       = $clog2(BYTES_PER_MATRIX)
) (
  input logic clk,
  input logic rst,
  matrix_frame_sequencer_if.master bus
);
  localparam int DW      = CHANNEL_NUMBER * SPI_SIZE;
  localparam int TMO_W   = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam int COL_DIV = (BYTES_PER_COLUMN == 0) ? 1 : BYTES_PER_COLUMN;

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_IMG      = 4'd1;
  localparam logic [3:0] S_IMG_ACK  = 4'd2;
  localparam logic [3:0] S_IMG_RDY  = 4'd3;
  localparam logic [3:0] S_FETCH    = 4'd4;
  localparam logic [3:0] S_LOAD     = 4'd5;
  localparam logic [3:0] S_SEND     = 4'd6;
  localparam logic [3:0] S_BYTE_ACK = 4'd7;
  localparam logic [3:0] S_BYTE_RDY = 4'd8;
  localparam logic [3:0] S_END      = 4'd9;

  logic [3:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [TMO_W-1:0]      r_tmo;
  logic [1:0]            r_mode;
  logic [SPI_SIZE-1:0]   r_fill;
  logic [DW-1:0]         r_data;
  logic [15:0]           r_frame_count;
  logic                  r_ack_error;

  logic [DW-1:0]         w_load_data;
  logic                  w_col;
  logic                  w_last;
  logic                  w_tmo_hit;
  logic                  w_start;

  // Pattern generators share the FETCH/LOAD slots with the frame buffer path
  always_comb begin
    w_load_data = '0;
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      case (r_mode)
        2'd0:    w_load_data[c*SPI_SIZE +: SPI_SIZE] = bus.rd_data[c*SPI_SIZE +: SPI_SIZE];
        2'd1:    w_load_data[c*SPI_SIZE +: SPI_SIZE] = r_fill;
        2'd2:    w_load_data[c*SPI_SIZE +: SPI_SIZE] = SPI_SIZE'(r_idx) + SPI_SIZE'(c);
        default: w_load_data[c*SPI_SIZE +: SPI_SIZE] = {SPI_SIZE{r_idx[0] ^ ((c % 2) == 1)}};
      endcase
    end
  end

  assign w_col     = (BYTES_PER_COLUMN != 0) && (r_idx != '0) &&
                     ((int'(r_idx) % COL_DIV) == 0);
  assign w_last    = (r_idx == ADDR_WIDTH'(BYTES_PER_MATRIX - 1));
  assign w_tmo_hit = (r_tmo == TMO_W'(ACK_TIMEOUT - 1));
  assign w_start   = bus.enable && bus.tx_finish;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_tmo         <= '0;
      r_mode        <= '0;
      r_fill        <= '0;
      r_data        <= '0;
      r_frame_count <= '0;
      r_ack_error   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_start) begin
          r_mode  <= bus.mode;
          r_fill  <= bus.fill_word;
          r_idx   <= '0;
          r_state <= S_IMG;
        end
        S_IMG: begin
          r_tmo   <= '0;
          r_state <= S_IMG_ACK;
        end
        S_IMG_ACK: if (!bus.tx_finish) begin
          r_tmo   <= '0;
          r_state <= S_IMG_RDY;
        end else if (w_tmo_hit) begin
          r_tmo       <= '0;
          r_ack_error <= 1'b1;
          r_state     <= S_IMG;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
        S_IMG_RDY: if (bus.tx_finish) r_state <= S_FETCH;
        S_FETCH:   r_state <= S_LOAD;
        S_LOAD: begin
          r_data  <= w_load_data;
          r_state <= S_SEND;
        end
        S_SEND: begin
          r_tmo   <= '0;
          r_state <= S_BYTE_ACK;
        end
        // A missed acknowledge re-pulses the same word; data_out is untouched
        S_BYTE_ACK: if (!bus.tx_finish) begin
          r_tmo   <= '0;
          r_state <= S_BYTE_RDY;
        end else if (w_tmo_hit) begin
          r_tmo       <= '0;
          r_ack_error <= 1'b1;
          r_state     <= S_SEND;
        end else begin
          r_tmo <= r_tmo + 1'b1;
        end
        S_BYTE_RDY: if (bus.tx_finish) begin
          if (w_last) begin
            r_state <= S_END;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_END: begin
          r_frame_count <= r_frame_count + 16'd1;
          if (w_start) begin
            r_mode  <= bus.mode;
            r_fill  <= bus.fill_word;
            r_idx   <= '0;
            r_state <= S_IMG;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rd_en       = (r_state == S_FETCH) && (r_mode == 2'd0);
  assign bus.rd_addr     = r_idx;
  assign bus.data_out    = r_data;
  assign bus.new_image   = (r_state == S_IMG);
  assign bus.next_data   = (r_state == S_SEND);
  assign bus.new_column  = (r_state == S_SEND) && w_col;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.frame_done  = (r_state == S_END);
  assign bus.frame_count = r_frame_count;
  assign bus.ack_error   = r_ack_error;
endmodule

// File: tb/tb_matrix_frame_sequencer.sv
// Scoreboard bench for matrix_frame_sequencer: randomized frames against a
// pattern/frame-buffer reference model, with a responsive output_module model.
module tb_matrix_frame_sequencer;
  localparam int CN  = 3;
  localparam int SS  = 8;
  localparam int BPM = 6;
  localparam int BPC = 2;
  localparam int TMO = 8;
  localparam int AW  = $clog2(BPM);
  localparam int DW  = CN * SS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_frame_sequencer_if #(.CHANNEL_NUMBER(CN), .SPI_SIZE(SS), .ADDR_WIDTH(AW)) bus();

  matrix_frame_sequencer #(
    .CHANNEL_NUMBER(CN), .SPI_SIZE(SS), .BYTES_PER_MATRIX(BPM),
    .BYTES_PER_COLUMN(BPC), .ACK_TIMEOUT(TMO), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          col;
    int            gap;
  } exp_t;

  exp_t          exp_q[$];
  int            addr_q[$];
  logic [DW-1:0] mem [BPM];

  int errors = 0, checks = 0;
  int img_seen = 0, nd_seen = 0, done_seen = 0, cyc = 0, last_nd = 0;
  int nd_total = 0, stall_nd = -1, exp_frames = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp_v, $time);
    end
  endtask

  // Reference: each channel word follows directly from mode, fill, index and channel
  function automatic logic [DW-1:0] model(input int m, input logic [SS-1:0] f, input int idx);
    logic [DW-1:0] w;
    w = '0;
    for (int c = 0; c < CN; c++) begin
      case (m)
        0:       w[c*SS +: SS] = mem[idx][c*SS +: SS];
        1:       w[c*SS +: SS] = f;
        2:       w[c*SS +: SS] = SS'((idx + c) % 256);
        default: w[c*SS +: SS] = (((idx + c) % 2) == 1) ? 8'hFF : 8'h00;
      endcase
    end
    return w;
  endfunction

  task automatic push_frame(input int m, input logic [SS-1:0] f, input int stall_word);
    exp_t e;
    if (m == 0)
      for (int i = 0; i < BPM; i++) mem[i] = DW'($urandom);
    for (int i = 0; i < BPM; i++) begin
      e.data = model(m, f, i);
      e.col  = (i != 0) && ((i % BPC) == 0);
      e.gap  = 0;
      exp_q.push_back(e);
      if (i == stall_word) begin
        e.gap = TMO + 1;
        exp_q.push_back(e);
      end
      if (m == 0) addr_q.push_back(i);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (bus.new_image) img_seen++;
        if (bus.frame_done) done_seen++;
        if (bus.new_image && bus.next_data) chk("pulse_exclusive", 1, 0);
        if (bus.new_column && !bus.next_data) chk("column_without_data", 1, 0);
        if (bus.next_data) begin
          nd_seen++;
          if (exp_q.size() == 0) begin
            chk("unexpected_next_data", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("data_out", 32'(bus.data_out), 32'(e.data));
            chk("new_column", 32'(bus.new_column), 32'(e.col));
            if (e.gap != 0) chk("repulse_gap", cyc - last_nd, e.gap);
          end
          last_nd = cyc;
        end
        if (bus.rd_en) begin
          if (addr_q.size() == 0) chk("unexpected_rd_en", 1, 0);
          else chk("rd_addr", 32'(bus.rd_addr), addr_q.pop_front());
        end
      end
    end
  endtask

  // output_module model: drops tx_finish for 1..3 cycles after each pulse
  task automatic responder();
    int lat;
    forever begin
      @(posedge clk);
      if (!rst && (bus.new_image || bus.next_data)) begin
        if (bus.next_data) nd_total++;
        if (!(bus.next_data && nd_total == stall_nd)) begin
          lat = $urandom_range(1, 3);
          #1 bus.tx_finish = 1'b0;
          repeat (lat) @(posedge clk);
          #1 bus.tx_finish = 1'b1;
        end
      end
    end
  endtask

  task automatic fbuf();
    int a;
    forever begin
      @(posedge clk);
      if (bus.rd_en) begin
        a = int'(bus.rd_addr);
        #1 bus.rd_data = mem[a];
      end
    end
  endtask

  task automatic watchdog();
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  endtask

  task automatic wait_img(input int target);
    int n = 0;
    while (img_seen < target && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("new_image_seen", 32'(img_seen >= target), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (bus.busy && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall", 32'(bus.busy), 0);
  endtask

  task automatic end_checks(input int img_before);
    chk("frame_count", 32'(bus.frame_count), exp_frames);
    chk("frame_done_count", done_seen, exp_frames);
    chk("words_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
    repeat (10) @(negedge clk);
    chk("no_extra_image", img_seen, img_before);
  endtask

  task automatic run_frame(input int m, input logic [SS-1:0] f, input int stall_word);
    int start_img;
    push_frame(m, f, stall_word);
    if (stall_word >= 0) stall_nd = nd_total + stall_word + 1;
    @(negedge clk);
    bus.mode = 2'(m); bus.fill_word = f; bus.enable = 1'b1;
    start_img = img_seen;
    wait_img(start_img + 1);
    @(negedge clk);
    bus.enable = 1'b0; bus.mode = 2'($urandom); bus.fill_word = SS'($urandom);
    wait_idle();
    exp_frames++;
    stall_nd = -1;
    end_checks(start_img + 1);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_new_image"}, 32'(bus.new_image), 0);
    chk({tag, "_next_data"}, 32'(bus.next_data), 0);
    chk({tag, "_new_column"}, 32'(bus.new_column), 0);
    chk({tag, "_frame_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({tag, "_data_out"}, 32'(bus.data_out), 0);
    chk({tag, "_frame_count"}, 32'(bus.frame_count), 0);
    chk({tag, "_ack_error"}, 32'(bus.ack_error), 0);
  endtask

  initial begin
    int start_img, start_nd, done_before, n;
    logic [SS-1:0] fb;
    rst = 1'b1;
    bus.enable = 1'b0; bus.mode = 2'd0; bus.fill_word = '0;
    bus.tx_finish = 1'b1; bus.rd_data = '0;
    fork
      monitor_loop();
      responder();
      fbuf();
      watchdog();
    join_none
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    run_frame(1, 8'hA5, -1);
    run_frame(0, 8'h00, -1);
    run_frame(2, 8'h3C, -1);
    run_frame(3, 8'h00, -1);

    chk("ack_error_before_stall", 32'(bus.ack_error), 0);
    run_frame(1, 8'h5A, 1);
    chk("ack_error_after_stall", 32'(bus.ack_error), 1);

    for (int k = 0; k < 4; k++) run_frame($urandom_range(0, 3), SS'($urandom), -1);

    // Back-to-back frames: inputs changed mid-frame only take effect at the next start
    fb = SS'($urandom);
    push_frame(1, 8'hC3, -1);
    push_frame(2, fb, -1);
    @(negedge clk);
    bus.mode = 2'd1; bus.fill_word = 8'hC3; bus.enable = 1'b1;
    start_img = img_seen;
    wait_img(start_img + 1);
    @(negedge clk);
    bus.mode = 2'd2; bus.fill_word = fb;
    wait_img(start_img + 2);
    @(negedge clk);
    bus.enable = 1'b0;
    wait_idle();
    exp_frames += 2;
    end_checks(start_img + 2);

    // Reset in the middle of word 5
    push_frame(0, 8'h00, -1);
    @(negedge clk);
    bus.mode = 2'd0; bus.enable = 1'b1;
    start_nd = nd_seen;
    done_before = done_seen;
    n = 0;
    while (nd_seen < start_nd + 5 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("reached_word5", 32'(nd_seen >= start_nd + 5), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midframe_reset");
    exp_q.delete();
    addr_q.delete();
    bus.enable = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("no_done_on_abort", done_seen, done_before);
    exp_frames = 0;
    done_seen = 0;
    run_frame(0, 8'h00, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
